// File: rtl/systolic_data_setup.sv
// systolic_data_setup: input skew stage in front of the MAC array.
// Each row-vector byte is sign- or zero-extended, then lane i is delayed by
// i+1 enabled cycles so the array sees a diagonal wavefront. A valid bit
// travels alongside every element so the array knows which rows are live.
// Optional feature: define SYSTOLIC_SETUP_OCCUPANCY_EN to add the
// 'occupancy' output counting vectors still inside the skew.
module systolic_data_setup #(
   parameter int MATRIX_WIDTH = 8,
   parameter int BYTE_WIDTH   = 8,
   parameter int EXT_WIDTH    = 9
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              signed_mode,
   input  logic                              in_valid,
   input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] data_in,
   output logic [MATRIX_WIDTH*EXT_WIDTH-1:0]  data_out,
   output logic [MATRIX_WIDTH-1:0]            lane_valid,
   output logic                              busy
`ifdef SYSTOLIC_SETUP_OCCUPANCY_EN
   ,
   output logic [$clog2(MATRIX_WIDTH+1)-1:0]  occupancy
`endif
);

   // Extend one input byte to the MAC element width. In signed mode the
   // byte's MSB is replicated into the extra bit, otherwise it is zero.
   function automatic logic [EXT_WIDTH-1:0] extend_byte(
      input logic [BYTE_WIDTH-1:0] b,
      input logic                  sm
   );
      logic signed [BYTE_WIDTH-1:0] sb;
      logic                         top;
      sb  = signed'(b);
      top = sm & sb[BYTE_WIDTH-1];
      return {top, b};
   endfunction

   // Extended elements entering the first stage of each lane. Idle cycles
   // inject zeros so the MACs accumulate nothing for empty slots.
   logic [EXT_WIDTH-1:0]    ext_p0 [MATRIX_WIDTH];
   // OR of every valid bit in a lane except its final stage: these are the
   // bits that will still be inside the skew after the next shift.
   logic [MATRIX_WIDTH-1:0] lane_pre_vld;

   // Extension of every lane at the input.
   always_comb begin
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
         ext_p0[i] = '0;
         if (in_valid) begin
            ext_p0[i] = extend_byte(data_in[i*BYTE_WIDTH +: BYTE_WIDTH], signed_mode);
         end
      end
   end

   for (genvar g = 0; g < MATRIX_WIDTH; g++) begin : g_lane
      localparam int DEPTH = g + 1;

      logic [EXT_WIDTH-1:0] dat_p [DEPTH];
      logic [DEPTH-1:0]     vld_p;

      // Shift chain for this lane: element and valid bit move together,
      // and nothing moves while enable is low.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
               dat_p[j] <= '0;
            end
            vld_p <= '0;
         end else if (enable) begin
            dat_p[0] <= ext_p0[g];
            vld_p[0] <= in_valid;
            for (int j = 1; j < DEPTH; j++) begin
               dat_p[j] <= dat_p[j-1];
               vld_p[j] <= vld_p[j-1];
            end
         end
      end

      assign data_out[g*EXT_WIDTH +: EXT_WIDTH] = dat_p[DEPTH-1];
      assign lane_valid[g]                      = vld_p[DEPTH-1];

      if (DEPTH > 1) begin : g_pre
         assign lane_pre_vld[g] = |vld_p[DEPTH-2:0];
      end else begin : g_pre_none
         assign lane_pre_vld[g] = 1'b0;
      end
   end

   // busy is kept as its own flop holding the OR of all valid bits as they
   // will be after the shift, so the output is registered yet exact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
      end else if (enable) begin
         busy <= in_valid | (|lane_pre_vld);
      end
   end

`ifdef SYSTOLIC_SETUP_OCCUPANCY_EN
   localparam int                OCC_W   = $clog2(MATRIX_WIDTH+1);
   localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(MATRIX_WIDTH);

   logic occ_inc;
   logic occ_dec;

   assign occ_inc = in_valid;
   assign occ_dec = lane_valid[MATRIX_WIDTH-1];

   // Vectors entered minus vectors that have left the last lane; entry and
   // exit on the same cycle cancel. Clamped to 0..MATRIX_WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else if (enable) begin
         case ({occ_inc, occ_dec})
            2'b10: if (occupancy != OCC_MAX) occupancy <= occupancy + OCC_W'(1);
            2'b01: if (occupancy != '0)      occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end
`endif

endmodule

// File: doc/systolic_data_setup.md
Name: systolic_data_setup

Overview:
- Input skew stage directly upstream of the MAC array.
- Takes one row vector of MATRIX_WIDTH bytes per cycle and sign- or zero-extends each byte to the MAC's extended-byte width.
- Delays lane i by i+1 enabled cycles, producing the diagonal wavefront the systolic array expects on data_in.
- Tracks per-lane validity so downstream control knows which MAC rows are receiving real data.

Parameters:
- MATRIX_WIDTH, 8: number of lanes (array rows); legal range 2..32.
- BYTE_WIDTH, 8: input element width in bits.
- EXT_WIDTH, 9: output element width in bits (extended_byte_type); must equal BYTE_WIDTH+1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  advances all skew registers; low holds all state.
- signed_mode  input  1  1 = sign-extend inputs, 0 = zero-extend; sampled with each vector.
- in_valid  input  1  data_in carries a real vector this cycle.
- data_in  input  MATRIX_WIDTH*BYTE_WIDTH  lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- data_out  output  MATRIX_WIDTH*EXT_WIDTH  skewed, extended lanes to the MAC array.
- lane_valid  output  MATRIX_WIDTH  bit i = data_out lane i holds valid data.
- busy  output  1  any valid element still in flight in any lane.

Behaviour:
- Reset: async on rst high. Every skew register, data_out, lane_valid and busy go to 0 immediately and stay 0 while rst is high.
- Extension (per lane, at input):
  - signed_mode=1: ext = {in[BYTE_WIDTH-1], in}.
  - signed_mode=0: ext = {1'b0, in}.
- Invalid input (in_valid=0 on an enabled cycle): a zero element with valid=0 is inserted into every lane's first stage, so MACs accumulate 0.
- Skew:
  - Lane i is a shift chain of i+1 registers (element + valid bit).
  - data_out lane i is the last stage of chain i, so lane i output equals lane i input from exactly i+1 enabled cycles earlier.
  - Total register stages: MATRIX_WIDTH*(MATRIX_WIDTH+1)/2.
- Enable low: no chain shifts; data_out, lane_valid and busy hold. in_valid and data_in are ignored that cycle; no element is dropped or duplicated.
- Latency:
  - First vector accepted on enabled cycle t appears on lane 0 after edge t+1 and on lane MATRIX_WIDTH-1 after edge t+MATRIX_WIDTH.
  - Throughput is one vector per enabled cycle; there is no backpressure output.
- busy = OR of every valid bit in every stage. It deasserts MATRIX_WIDTH enabled cycles after the last valid vector.
- Simultaneous events:
  - rst dominates enable.
  - A valid vector entering while the previous vector is mid-skew is legal; the two diagonals never collide.
- Reset mid-operation: in-flight data is discarded with no partial drain. The first vector after rst falls behaves as from power-up.
- Timing: no combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SYSTOLIC_SETUP_OCCUPANCY_EN.
- Defined: adds output port occupancy, width $clog2(MATRIX_WIDTH+1).
  - Counts distinct valid vectors that have entered and not yet fully exited lane MATRIX_WIDTH-1.
  - +1 on an enabled cycle with in_valid; -1 on an enabled cycle where the last-lane valid bit shifts out.
  - Both on the same cycle: net 0.
  - Resets to 0; saturates at MATRIX_WIDTH.
- Not defined: the port does not exist and busy is the only drain indicator.

Test Plan:
- Reset: MATRIX_WIDTH=4. Assert rst mid-cycle with valid data in flight -> data_out=0, lane_valid=4'b0000, busy=0 before the next clk edge.
- Skew latency: enable=1, one vector {0x04,0x03,0x02,0x01} (lane3..lane0), signed_mode=0, then in_valid=0 -> lane0=1 at edge 1, lane1=2 at edge 2, lane2=3 at edge 3, lane3=4 at edge 4; lane_valid walks 0001, 0010, 0100, 1000; busy falls after edge 5.
- Extension: lane0 input 0x80 -> signed_mode=1 gives 9'h180 (-128); signed_mode=0 gives 9'h080 (128).
- Stall: back-to-back vectors A and B, enable low 3 cycles mid-skew -> outputs frozen during the stall; afterwards the sequence matches the no-stall run exactly, with no lost or repeated lane values.
- Streaming: 10 consecutive valid vectors with lane i value = 16*k+i for vector k -> lane i shows 16*k+i at edge k+i+1, and lane_valid=1111 from edge 4 through edge 10.
- Occupancy (macro defined): 3 valid vectors, then idle -> occupancy 1, 2, 3, holds 3, then decrements to 0 once vector 2 leaves lane 3.
